// File: rtl/reset_seq_pf_if.sv
// Pin bundle for reset_seq_pf: qualification inputs and staged reset outputs.
// Status outputs SEQ_STATE/LOSS_COUNT exist only when RESET_SEQ_STATUS_EN is defined.
interface reset_seq_pf_if #(
  parameter int NUM_CH   = 4,
  parameter int NUM_LOCK = 2,
  parameter int NUM_BANK = 2,
  parameter int CNT_W    = 16
);
  logic                EXT_RST_N;
  logic                INIT_DONE;
  logic [NUM_BANK-1:0] BANK_VDDI_STATUS;
  logic [NUM_LOCK-1:0] PLL_LOCK;
  logic                SS_BUSY;
  logic                FF_US_RESTORE;
  logic                PLL_POWERDOWN_B;
  logic [NUM_CH-1:0]   FABRIC_RESET_N;
  logic                SEQ_DONE;
`ifdef RESET_SEQ_STATUS_EN
  logic [1:0]          SEQ_STATE;
  logic [CNT_W-1:0]    LOSS_COUNT;
`else
  // no status outputs in this build
`endif

  modport master (
    output EXT_RST_N, INIT_DONE, BANK_VDDI_STATUS, PLL_LOCK, SS_BUSY, FF_US_RESTORE,
    input  PLL_POWERDOWN_B, FABRIC_RESET_N, SEQ_DONE
`ifdef RESET_SEQ_STATUS_EN
    , input SEQ_STATE, LOSS_COUNT
`endif
  );

  modport slave (
    input  EXT_RST_N, INIT_DONE, BANK_VDDI_STATUS, PLL_LOCK, SS_BUSY, FF_US_RESTORE,
    output PLL_POWERDOWN_B, FABRIC_RESET_N, SEQ_DONE
`ifdef RESET_SEQ_STATUS_EN
    , output SEQ_STATE, LOSS_COUNT
`endif
  );
endinterface

// File: rtl/reset_seq_pf.sv
// Fabric reset sequencer: qualifies supplies/locks, then releases NUM_CH domains in order.
// Optional RESET_SEQ_STATUS_EN adds SEQ_STATE and a saturating LOSS_COUNT.
module reset_seq_pf #(
  parameter int NUM_CH        = 4,
  parameter int NUM_LOCK      = 2,
  parameter int NUM_BANK      = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int STAGE_DLY     = 8,
  parameter int CNT_W         = 16
) (
  input logic           CLK,
  input logic           RST,
  reset_seq_pf_if.slave bus
);
  localparam int NA     = 4 + NUM_BANK + NUM_LOCK;
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int STG_W  = (NUM_CH > 1) ? $clog2((NUM_CH - 1) * STAGE_DLY + 1) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'((NUM_CH - 1) * STAGE_DLY);

  typedef enum logic [1:0] {IDLE = 2'd0, STABLE = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_t;

  logic [NA-1:0]       async_in, sync_q1, sync_q2;
  logic                ext_rst_n_s, init_done_s, ss_busy_s, ff_us_restore_s;
  logic [NUM_BANK-1:0] bank_vddi_status_s;
  logic [NUM_LOCK-1:0] pll_lock_s;
  logic                vddi_ok, run_ok, start_ok, go_release, abort;

  state_t              state;
  logic [STAB_W-1:0]   stab_cnt;
  logic [STG_W-1:0]    stage_cnt, stage_nxt;
  logic [NUM_CH-1:0]   fab_q;
  logic                done_q, pdb_q;

  // All async inputs share one 2-flop chain; clearing to 0 means "not ready".
  assign async_in = {bus.EXT_RST_N, bus.INIT_DONE, bus.SS_BUSY, bus.FF_US_RESTORE,
                     bus.BANK_VDDI_STATUS, bus.PLL_LOCK};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
    end
  end

  assign {ext_rst_n_s, init_done_s, ss_busy_s, ff_us_restore_s,
          bank_vddi_status_s, pll_lock_s} = sync_q2;

  assign vddi_ok  = &bank_vddi_status_s;
  assign run_ok   = ext_rst_n_s & init_done_s & vddi_ok & (&pll_lock_s);
  assign start_ok = run_ok & ~ss_busy_s & ~ff_us_restore_s;

  // The edge closing the STABLE_CYCLES-th qualified cycle; with one cycle that is the IDLE edge.
  assign go_release = start_ok &&
                      ((state == IDLE && STABLE_CYCLES == 1) ||
                       (state == STABLE && stab_cnt == STAB_LAST));
  assign abort      = (state == RELEASE || state == RUN) && !run_ok;
  assign stage_nxt  = stage_cnt + STG_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      stab_cnt  <= '0;
      stage_cnt <= '0;
      fab_q     <= '0;
      done_q    <= 1'b0;
      pdb_q     <= 1'b0;
    end else begin
      pdb_q <= init_done_s & vddi_ok;
      if (abort) begin
        state     <= IDLE;
        stab_cnt  <= '0;
        stage_cnt <= '0;
        fab_q     <= '0;
        done_q    <= 1'b0;
      end else if (go_release) begin
        stab_cnt  <= '0;
        stage_cnt <= '0;
        fab_q     <= '0;
        fab_q[0]  <= 1'b1;
        if (NUM_CH == 1) begin
          state  <= RUN;
          done_q <= 1'b1;
        end else begin
          state <= RELEASE;
        end
      end else begin
        case (state)
          IDLE: begin
            stab_cnt  <= '0;
            stage_cnt <= '0;
            fab_q     <= '0;
            done_q    <= 1'b0;
            if (start_ok) begin
              state    <= STABLE;
              stab_cnt <= STAB_W'(1);
            end
          end
          STABLE: begin
            if (!start_ok) begin
              state    <= IDLE;
              stab_cnt <= '0;
            end else begin
              stab_cnt <= stab_cnt + STAB_W'(1);
            end
          end
          RELEASE: begin
            stage_cnt <= stage_nxt;
            for (int k = 1; k < NUM_CH; k++)
              if (stage_nxt >= STG_W'(k * STAGE_DLY)) fab_q[k] <= 1'b1;
            if (stage_nxt == STG_LAST) begin
              state  <= RUN;
              done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.FABRIC_RESET_N  = fab_q;
  assign bus.SEQ_DONE        = done_q;
  assign bus.PLL_POWERDOWN_B = pdb_q;

`ifdef RESET_SEQ_STATUS_EN
  logic [CNT_W-1:0] loss_q;

  always_ff @(posedge CLK) begin
    if (RST) loss_q <= '0;
    else if (abort && loss_q != '1) loss_q <= loss_q + CNT_W'(1);
  end

  assign bus.SEQ_STATE  = state;
  assign bus.LOSS_COUNT = loss_q;
`else
  // status outputs and loss counter are not built
`endif
endmodule

// File: tb/tb_reset_seq_pf.sv
// Directed bench for reset_seq_pf: table-driven release timeline plus abort/glitch sequences.
module tb_reset_seq_pf;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reset_seq_pf_if #(.NUM_CH(4), .NUM_LOCK(2), .NUM_BANK(2), .CNT_W(16)) bus ();

  reset_seq_pf #(.NUM_CH(4), .NUM_LOCK(2), .NUM_BANK(2), .STABLE_CYCLES(16),
                 .STAGE_DLY(8), .CNT_W(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  // ins = {EXT_RST_N, INIT_DONE, VDDI[1:0], LOCK[1:0], SS_BUSY, FF_US_RESTORE}
  typedef struct {
    logic [7:0] ins;
    int         n;
    logic [3:0] fab;
    logic       done;
    logic       pdb;
  } vec_t;

  localparam logic [7:0] GOOD = 8'b1111_1100;
  vec_t vecs[10];

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic [7:0] ins);
    {bus.EXT_RST_N, bus.INIT_DONE, bus.BANK_VDDI_STATUS, bus.PLL_LOCK,
     bus.SS_BUSY, bus.FF_US_RESTORE} = ins;
  endtask

  task automatic chk(input string nm, input logic [3:0] ef, input logic ed, input logic ep);
    checks++;
    if (bus.FABRIC_RESET_N !== ef || bus.SEQ_DONE !== ed || bus.PLL_POWERDOWN_B !== ep) begin
      errors++;
      $display("FAIL %s: got fab=%b done=%b pdb=%b, want fab=%b done=%b pdb=%b", nm,
               bus.FABRIC_RESET_N, bus.SEQ_DONE, bus.PLL_POWERDOWN_B, ef, ed, ep);
    end
  endtask

  task automatic chk_st(input string nm, input logic [1:0] es, input int el);
`ifdef RESET_SEQ_STATUS_EN
    checks++;
    if (bus.SEQ_STATE !== es || int'(bus.LOSS_COUNT) != el) begin
      errors++;
      $display("FAIL %s: got state=%0d loss=%0d, want state=%0d loss=%0d", nm,
               bus.SEQ_STATE, bus.LOSS_COUNT, es, el);
    end
`else
    if (nm.len() < 0) $display("%0d %0d", es, el);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Release timeline from reset deassert (edge counts relative to that point)
    vecs[0] = '{GOOD, 2,  4'b0000, 1'b0, 1'b0};
    vecs[1] = '{GOOD, 1,  4'b0000, 1'b0, 1'b1};
    vecs[2] = '{GOOD, 14, 4'b0000, 1'b0, 1'b1};
    vecs[3] = '{GOOD, 1,  4'b0001, 1'b0, 1'b1};
    vecs[4] = '{GOOD, 7,  4'b0001, 1'b0, 1'b1};
    vecs[5] = '{GOOD, 1,  4'b0011, 1'b0, 1'b1};
    vecs[6] = '{GOOD, 7,  4'b0011, 1'b0, 1'b1};
    vecs[7] = '{GOOD, 1,  4'b0111, 1'b0, 1'b1};
    vecs[8] = '{GOOD, 7,  4'b0111, 1'b0, 1'b1};
    vecs[9] = '{GOOD, 1,  4'b1111, 1'b1, 1'b1};

    // Power-up reset with all inputs not ready
    drive(8'h00);
    tick(5);
    chk("reset", 4'b0000, 1'b0, 1'b0);
    chk_st("reset_st", 2'd0, 0);

    // Glitch on PLL_LOCK[1] during STABLE restarts the window
    RST = 1'b0;
    drive(GOOD);
    tick(3);
    chk("glitch_e3", 4'b0000, 1'b0, 1'b1);
    tick(6);
    drive(8'b1111_0100);
    tick(1);
    drive(GOOD);
    tick(17);
    chk("glitch_e27", 4'b0000, 1'b0, 1'b1);
    chk_st("glitch_e27_st", 2'd1, 0);
    tick(1);
    chk("glitch_e28", 4'b0001, 1'b0, 1'b1);
    tick(24);
    chk("glitch_e52", 4'b1111, 1'b1, 1'b1);
    chk_st("glitch_run_st", 2'd3, 0);

    // SS_BUSY / FF_US_RESTORE in RUN change nothing
    drive(8'b1111_1111);
    tick(6);
    chk("busy_run", 4'b1111, 1'b1, 1'b1);
    drive(GOOD);

    // One-cycle RST mid-RUN, then the table-driven resequence
    RST = 1'b1;
    tick(1);
    chk("rst_mid_run", 4'b0000, 1'b0, 1'b0);
    chk_st("rst_mid_run_st", 2'd0, 0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ins);
      tick(vecs[i].n);
      chk($sformatf("seq[%0d]", i), vecs[i].fab, vecs[i].done, vecs[i].pdb);
    end

    // Lock loss in RUN: abort on edge 3, then full resequence
    drive(8'b1111_1000);
    tick(2);
    chk("lockloss_e2", 4'b1111, 1'b1, 1'b1);
    tick(1);
    chk("lockloss_e3", 4'b0000, 1'b0, 1'b1);
    chk_st("lockloss_st", 2'd0, 1);
    drive(GOOD);
    tick(17);
    chk("relock_e17", 4'b0000, 1'b0, 1'b1);
    tick(1);
    chk("relock_e18", 4'b0001, 1'b0, 1'b1);
    tick(8);
    chk("relock_e26", 4'b0011, 1'b0, 1'b1);

    // EXT_RST_N low before edge 28 aborts mid-RELEASE on edge 30
    tick(1);
    drive(8'b0111_1100);
    tick(2);
    chk("abort_e29", 4'b0011, 1'b0, 1'b1);
    tick(1);
    chk("abort_e30", 4'b0000, 1'b0, 1'b1);
    chk_st("abort_st", 2'd0, 2);
    tick(12);
    chk("abort_e42", 4'b0000, 1'b0, 1'b1);

    // SS_BUSY and FF_US_RESTORE each block start from IDLE
    drive(8'b1111_1111);
    tick(25);
    chk("busy_idle", 4'b0000, 1'b0, 1'b1);
    drive(8'b1111_1101);
    tick(25);
    chk("ffr_idle", 4'b0000, 1'b0, 1'b1);
    drive(GOOD);
    tick(17);
    chk("unblock_e17", 4'b0000, 1'b0, 1'b1);
    tick(1);
    chk("unblock_e18", 4'b0001, 1'b0, 1'b1);
    tick(24);
    chk("unblock_e42", 4'b1111, 1'b1, 1'b1);

    // Bank supply loss in RUN: abort and PLL_POWERDOWN_B drop together
    drive(8'b1110_1100);
    tick(2);
    chk("vddi_e2", 4'b1111, 1'b1, 1'b1);
    tick(1);
    chk("vddi_e3", 4'b0000, 1'b0, 1'b0);
    chk_st("vddi_st", 2'd0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
